// File: rtl/entropy_collector_pkg.sv
// Shared constants for the entropy collector:
// API register map, FSM state encoding and block geometry.
package entropy_collector_pkg;

  localparam int WORDS_PER_BLOCK = 16;
  localparam int IDX_W = 5;

  localparam logic [7:0] ADDR_CTRL = 8'h08;
  localparam logic [7:0] ADDR_STATUS = 8'h09;
  localparam logic [7:0] ADDR_BLOCK_CTR = 8'h0a;
  localparam logic [7:0] ADDR_DISCARD_CTR = 8'h0b;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_DELIVER = 2'd2;

  function automatic logic is_ro(input logic [7:0] a);
    return (a == ADDR_STATUS) ||
           (a == ADDR_BLOCK_CTR) ||
           (a == ADDR_DISCARD_CTR);
  endfunction

endpackage

// File: rtl/entropy_collector.sv
// Collects 16 source words into a 512-bit block and hands it
// to the mixer with a syn/ack handshake; small register API.
module entropy_collector
  import entropy_collector_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         entropy_enabled,
  input  logic [31:0]  entropy_data,
  input  logic         entropy_valid,
  output logic         entropy_ack,
  output logic [511:0] block_data,
  output logic         block_syn,
  input  logic         block_ack,
  input  logic         cs,
  input  logic         we,
  input  logic [7:0]   address,
  input  logic [31:0]  write_data,
  output logic [31:0]  read_data,
  output logic         error
);

  logic [1:0] state_q, state_d;
  logic ctrl_en_q, ctrl_en_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [0:WORDS_PER_BLOCK-1][31:0] words_q, words_d;
  logic ack_q, ack_d;
  logic syn_q, syn_d;
  logic [31:0] blk_ctr_q, blk_ctr_d;
  logic [31:0] disc_ctr_q, disc_ctr_d;

  logic cap;
  logic last;
  logic ctrl_wr;
  logic unused_wdata;

  assign unused_wdata = ^write_data[31:1];

  assign ctrl_wr = cs && we && (address == ADDR_CTRL);

  // ack_q blocks back-to-back captures: one word per two cycles
  assign cap = (state_q == ST_COLLECT) && ctrl_en_q &&
               entropy_valid && entropy_enabled && !ack_q;

  assign last = (idx_q == IDX_W'(WORDS_PER_BLOCK - 1));

  always_comb begin
    state_d = state_q;
    ctrl_en_d = ctrl_en_q;
    idx_d = idx_q;
    words_d = words_q;
    ack_d = 1'b0;
    syn_d = syn_q;
    blk_ctr_d = blk_ctr_q;
    disc_ctr_d = disc_ctr_q;

    if (ctrl_wr) ctrl_en_d = write_data[0];

    case (state_q)
      ST_IDLE: begin
        if (ctrl_en_q && entropy_enabled) state_d = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (!ctrl_en_q) begin
          state_d = ST_IDLE;
          idx_d = '0;
          if (idx_q != '0) disc_ctr_d = disc_ctr_q + 32'd1;
        end else if (cap) begin
          words_d[idx_q[3:0]] = entropy_data;
          idx_d = idx_q + IDX_W'(1);
          ack_d = 1'b1;
          if (last) begin
            state_d = ST_DELIVER;
            syn_d = 1'b1;
          end
        end
      end
      ST_DELIVER: begin
        if (block_ack) begin
          syn_d = 1'b0;
          idx_d = '0;
          blk_ctr_d = blk_ctr_q + 32'd1;
          state_d = ctrl_en_q ? ST_COLLECT : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ctrl_en_q <= 1'b0;
      idx_q <= '0;
      words_q <= '0;
      ack_q <= 1'b0;
      syn_q <= 1'b0;
      blk_ctr_q <= '0;
      disc_ctr_q <= '0;
    end else begin
      state_q <= state_d;
      ctrl_en_q <= ctrl_en_d;
      idx_q <= idx_d;
      words_q <= words_d;
      ack_q <= ack_d;
      syn_q <= syn_d;
      blk_ctr_q <= blk_ctr_d;
      disc_ctr_q <= disc_ctr_d;
    end
  end

  assign entropy_ack = ack_q;
  assign block_syn = syn_q;
  assign block_data = words_q;

  logic is_ctrl, is_stat, is_bctr, is_dctr;

  assign is_ctrl = (address == ADDR_CTRL);
  assign is_stat = (address == ADDR_STATUS);
  assign is_bctr = (address == ADDR_BLOCK_CTR);
  assign is_dctr = (address == ADDR_DISCARD_CTR);

  always_comb begin
    read_data = 32'd0;
    error = 1'b0;
    if (cs) begin
      unique case (1'b1)
        is_ctrl: read_data = {31'd0, ctrl_en_q};
        is_stat: read_data = {18'd0, state_q, 3'd0,
                              idx_q, 3'd0, syn_q};
        is_bctr: read_data = blk_ctr_q;
        is_dctr: read_data = disc_ctr_q;
        default: error = 1'b1;
      endcase
      if (we && is_ro(address)) error = 1'b1;
    end
  end

endmodule

// File: tb/tb_entropy_collector.sv
// Directed bench for entropy_collector: block collection,
// delivery stall, discard, source pause, reset and API errors.
module tb_entropy_collector;

  logic         clk = 1'b0;
  logic         reset;
  logic         entropy_enabled;
  logic [31:0]  entropy_data;
  logic         entropy_valid;
  logic         entropy_ack;
  logic [511:0] block_data;
  logic         block_syn;
  logic         block_ack;
  logic         cs;
  logic         we;
  logic [7:0]   address;
  logic [31:0]  write_data;
  logic [31:0]  read_data;
  logic         error;

  int checks = 0;
  int failures = 0;
  int ack_cnt;
  int dbl_cnt;
  int syn_low;

  logic [31:0]  rdata;
  logic         rerr;
  logic [511:0] exp_blk;

  entropy_collector dut (
    .clk(clk),
    .reset(reset),
    .entropy_enabled(entropy_enabled),
    .entropy_data(entropy_data),
    .entropy_valid(entropy_valid),
    .entropy_ack(entropy_ack),
    .block_data(block_data),
    .block_syn(block_syn),
    .block_ack(block_ack),
    .cs(cs),
    .we(we),
    .address(address),
    .write_data(write_data),
    .read_data(read_data),
    .error(error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [511:0] obs,
                     input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [7:0] a,
                    output logic [31:0] d,
                    output logic e);
    cs = 1'b1;
    we = 1'b0;
    address = a;
    #1;
    d = read_data;
    e = error;
    cs = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    cs = 1'b1;
    we = 1'b1;
    address = a;
    write_data = d;
    tick();
    cs = 1'b0;
    we = 1'b0;
  endtask

  // Ticks until block_syn, ack_cnt == stop, or budget expires.
  // Each observed ack bumps entropy_data by inc for the next capture.
  task automatic run(input int budget, input int stop,
                     input logic [31:0] inc);
    bit prev = 1'b0;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (entropy_ack) begin
        if (prev) dbl_cnt++;
        ack_cnt++;
        entropy_data = entropy_data + inc;
      end
      prev = entropy_ack;
      if (block_syn || ack_cnt == stop) break;
    end
  endtask

  initial begin
    reset = 1'b1;
    entropy_enabled = 1'b0;
    entropy_data = 32'd0;
    entropy_valid = 1'b0;
    block_ack = 1'b0;
    cs = 1'b0;
    we = 1'b0;
    address = 8'd0;
    write_data = 32'd0;
    repeat (2) tick();
    reset = 1'b0;
    tick();

    chk("rst_ack", entropy_ack, 0);
    chk("rst_syn", block_syn, 0);
    chk("rst_data", block_data, 0);
    rd(8'h09, rdata, rerr);
    chk("rst_status", rdata, 0);
    rd(8'h0a, rdata, rerr);
    chk("rst_bctr", rdata, 0);

    // Constant source, one block
    entropy_enabled = 1'b1;
    entropy_valid = 1'b1;
    entropy_data = 32'h11223344;
    ack_cnt = 0;
    dbl_cnt = 0;
    wr(8'h08, 32'd1);
    run(100, 99, 32'd0);
    chk("c1_acks", ack_cnt, 16);
    chk("c1_alternate", dbl_cnt, 0);
    chk("c1_syn", block_syn, 1);
    chk("c1_syn_with_last_ack", entropy_ack, 1);
    chk("c1_block", block_data, {16{32'h11223344}});
    rd(8'h09, rdata, rerr);
    chk("c1_status", rdata, 32'h2101);
    rd(8'h0a, rdata, rerr);
    chk("c1_bctr", rdata, 0);

    // Mixer stalls 50 cycles
    entropy_data = 32'hAABBCCDD;
    ack_cnt = 0;
    syn_low = 0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (entropy_ack) ack_cnt++;
      if (!block_syn) syn_low++;
    end
    chk("stall_acks", ack_cnt, 0);
    chk("stall_syn_low", syn_low, 0);
    chk("stall_block", block_data, {16{32'h11223344}});
    block_ack = 1'b1;
    tick();
    block_ack = 1'b0;
    chk("dlv_syn", block_syn, 0);
    rd(8'h0a, rdata, rerr);
    chk("dlv_bctr", rdata, 1);
    rd(8'h09, rdata, rerr);
    chk("dlv_status", rdata, 32'h1000);
    tick();
    chk("restart_ack", entropy_ack, 1);

    // Disable after 5 words
    ack_cnt = 1;
    dbl_cnt = 0;
    run(50, 5, 32'd0);
    chk("dis_acks", ack_cnt, 5);
    rd(8'h09, rdata, rerr);
    chk("dis_status_pre", rdata, 32'h1050);
    entropy_valid = 1'b0;
    wr(8'h08, 32'd0);
    tick();
    rd(8'h09, rdata, rerr);
    chk("dis_status", rdata, 0);
    rd(8'h0b, rdata, rerr);
    chk("dis_dctr", rdata, 1);
    entropy_valid = 1'b1;
    ack_cnt = 0;
    run(6, 99, 32'd0);
    chk("dis_no_ack", ack_cnt, 0);

    // Re-enable, incrementing words
    entropy_data = 32'hC0DE0000;
    for (int i = 0; i < 16; i++)
      exp_blk[511-32*i -: 32] = 32'hC0DE0000 + 32'(i);
    ack_cnt = 0;
    dbl_cnt = 0;
    wr(8'h08, 32'd1);
    run(100, 99, 32'd1);
    chk("re_acks", ack_cnt, 16);
    chk("re_alternate", dbl_cnt, 0);
    chk("re_block", block_data, exp_blk);
    block_ack = 1'b1;
    tick();
    block_ack = 1'b0;
    rd(8'h0a, rdata, rerr);
    chk("re_bctr", rdata, 2);

    // Source pause after 7 words
    entropy_data = 32'hBEEF0000;
    for (int i = 0; i < 16; i++)
      exp_blk[511-32*i -: 32] = 32'hBEEF0000 + 32'(i);
    ack_cnt = 0;
    dbl_cnt = 0;
    run(50, 7, 32'd1);
    chk("pz_acks_pre", ack_cnt, 7);
    entropy_enabled = 1'b0;
    ack_cnt = 0;
    run(10, 99, 32'd1);
    chk("pz_no_ack", ack_cnt, 0);
    rd(8'h09, rdata, rerr);
    chk("pz_status", rdata, 32'h1070);
    entropy_enabled = 1'b1;
    ack_cnt = 7;
    run(100, 99, 32'd1);
    chk("pz_acks", ack_cnt, 16);
    chk("pz_syn", block_syn, 1);
    chk("pz_block", block_data, exp_blk);

    // API errors while delivering
    cs = 1'b1;
    we = 1'b1;
    address = 8'h0a;
    write_data = 32'hFFFF_FFFF;
    #1;
    chk("err_wr_bctr", error, 1);
    tick();
    cs = 1'b0;
    we = 1'b0;
    rd(8'h0a, rdata, rerr);
    chk("err_bctr_kept", rdata, 2);
    chk("ok_bctr_err", rerr, 0);
    rd(8'h20, rdata, rerr);
    chk("err_unmapped", rerr, 1);
    chk("err_unmapped_data", rdata, 0);
    cs = 1'b1;
    we = 1'b1;
    address = 8'h09;
    #1;
    chk("err_wr_status", error, 1);
    cs = 1'b0;
    we = 1'b0;
    address = 8'h08;
    #1;
    chk("nocs_data", read_data, 0);
    chk("nocs_err", error, 0);
    rd(8'h08, rdata, rerr);
    chk("ctrl_rd", rdata, 1);

    // Reset during delivery
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rr_ack", entropy_ack, 0);
    chk("rr_syn", block_syn, 0);
    chk("rr_data", block_data, 0);
    rd(8'h09, rdata, rerr);
    chk("rr_status", rdata, 0);
    rd(8'h08, rdata, rerr);
    chk("rr_ctrl", rdata, 0);
    rd(8'h0b, rdata, rerr);
    chk("rr_dctr", rdata, 0);

    // block_ack outside DELIVER
    block_ack = 1'b1;
    tick();
    block_ack = 1'b0;
    rd(8'h0a, rdata, rerr);
    chk("stray_ack_bctr", rdata, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
